// File: rtl/regfile_dump.sv
// Debug read-out engine: walks a register-address range through one regfile read
// port and streams (address, data) snapshots over a valid/ready handshake.
module regfile_dump #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] rf_addr_n;
  logic [ADDR_WIDTH-1:0] out_addr_n;
  logic [DATA_WIDTH-1:0] out_data_n;
  logic                  out_valid_n;
  logic [ADDR_WIDTH-1:0] last_q, last_n;
  logic                  handshake;

  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rf_addr   <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      last_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      rf_addr   <= rf_addr_n;
      out_addr  <= out_addr_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      last_q    <= last_n;
      // Flags are decoded from the next state and registered so they never glitch.
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n     = state;
    rf_addr_n   = rf_addr;
    out_addr_n  = out_addr;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    last_n      = last_q;

    case (state)
      IDLE: begin
        if (start) begin
          last_n    = last_addr;
          rf_addr_n = first_addr;
          state_n   = FETCH;
        end
      end
      FETCH: begin
        out_data_n  = rf_data;
        out_addr_n  = rf_addr;
        out_valid_n = 1'b1;
        state_n     = SEND;
      end
      SEND: begin
        if (handshake) begin
          out_valid_n = 1'b0;
          if (out_addr == last_q) begin
            state_n = DONE;
          end else begin
            rf_addr_n = (rf_addr == ADDR_MAX) ? '0 : rf_addr + ADDR_WIDTH'(1);
            state_n   = FETCH;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: behavioural regfile plus an
// (address, data) scoreboard filled at start and drained on each handshake.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  logic [4:0]  sb_addr [$];
  logic [31:0] sb_data [$];

  int n_pass  = 0;
  int n_total = 0;

  assign rf_data = rf[rf_addr];

  always #5 clk = ~clk;

  regfile_dump #(.NUM_REGS(32), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .first_addr(first_addr),
    .last_addr (last_addr),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_identity();
    for (int i = 0; i < 32; i++) rf[i] = i;
  endtask

  // Called at a sample point with the DUT idle; returns just after the edge that takes start.
  task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
    logic [4:0] a;
    int n;
    n = int'(5'(l - f)) + 1;
    for (int k = 0; k < n; k++) begin
      a = 5'(f + 5'(k));
      sb_addr.push_back(a);
      sb_data.push_back(rf[a]);
    end
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic drain(input string tag, output int words, output int done_at);
    int cyc;
    logic [4:0]  ea;
    logic [31:0] ed;
    cyc = 0; words = 0; done_at = -1;
    while (cyc < 400 && done_at < 0) begin
      if (out_valid && out_ready) begin
        words++;
        n_total++;
        if (sb_addr.size() == 0) begin
          $display("FAIL %s extra_word: got addr=%0d data=%h, scoreboard empty", tag, out_addr, out_data);
        end else begin
          ea = sb_addr.pop_front();
          ed = sb_data.pop_front();
          if ({out_addr, out_data} !== {ea, ed})
            $display("FAIL %s word: got addr=%0d data=%h, want addr=%0d data=%h", tag, out_addr, out_data, ea, ed);
          else n_pass++;
        end
      end
      if (done) done_at = cyc;
      tick();
      cyc++;
    end
    n_total++;
    if (done_at < 0) $display("FAIL %s done_timeout: done not seen within 400 cycles, want a pulse", tag);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b1; first_addr = '0; last_addr = '0;
    fill_identity();
    #2;
    n_total++;
    if ({out_valid, busy, done, out_addr, out_data, rf_addr} !== '0)
      $display("FAIL reset_power_on: got valid=%b busy=%b done=%b addr=%0d data=%h rf_addr=%0d, want all 0",
               out_valid, busy, done, out_addr, out_data, rf_addr);
    else n_pass++;
    tick(); tick();
    reset = 1'b0;
    tick();
    start_dump(5'd0, 5'd31);
    tick(); tick(); tick();
    #3 reset = 1'b1;
    #1;
    n_total++;
    if ({out_valid, busy, done, out_addr, out_data, rf_addr} !== '0)
      $display("FAIL reset_immediate: got valid=%b busy=%b done=%b addr=%0d data=%h rf_addr=%0d, want all 0",
               out_valid, busy, done, out_addr, out_data, rf_addr);
    else n_pass++;
    sb_addr.delete(); sb_data.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    n_total++;
    if ({busy, out_valid, done} !== 3'b000)
      $display("FAIL reset_release: got busy=%b valid=%b done=%b, want 0 0 0", busy, out_valid, done);
    else n_pass++;
  endtask

  task automatic test_full_dump();
    int words, done_at;
    fill_identity();
    out_ready = 1'b1;
    start_dump(5'd0, 5'd31);
    n_total++;
    if ({busy, out_valid} !== 2'b10) $display("FAIL full_fetch_cycle: got busy=%b valid=%b, want 1 0", busy, out_valid);
    else n_pass++;
    drain("full", words, done_at);
    n_total++;
    if (words !== 32) $display("FAIL full_count: got %0d words, want 32", words);
    else n_pass++;
    n_total++;
    if (done_at !== 64) $display("FAIL full_latency: done at cycle %0d after start edge, want 64", done_at);
    else n_pass++;
    n_total++;
    if ({done, busy} !== 2'b00) $display("FAIL full_done_pulse: got done=%b busy=%b after pulse, want 0 0", done, busy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int cyc, words, rise_cyc;
    bit stalled;
    logic [4:0]  ea;
    logic [31:0] ed;
    fill_identity();
    out_ready = 1'b1;
    start_dump(5'd0, 5'd7);
    cyc = 0; words = 0; rise_cyc = -1; stalled = 1'b0;
    while (cyc < 200 && !done) begin
      if (out_valid && out_addr == 5'd3 && !stalled) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick(); cyc++;
          n_total++;
          if ({out_valid, out_addr, out_data} !== {1'b1, 5'd3, 32'd3})
            $display("FAIL bp_hold: stall %0d got valid=%b addr=%0d data=%h, want 1 3 3", s, out_valid, out_addr, out_data);
          else n_pass++;
        end
        out_ready = 1'b1;
        rise_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        words++;
        if (out_addr == 5'd4) begin
          n_total++;
          if (cyc - rise_cyc !== 2) $display("FAIL bp_resume: word 4 %0d cycles after ready, want 2", cyc - rise_cyc);
          else n_pass++;
        end
        ea = sb_addr.pop_front();
        ed = sb_data.pop_front();
        n_total++;
        if ({out_addr, out_data} !== {ea, ed})
          $display("FAIL bp_word: got addr=%0d data=%h, want addr=%0d data=%h", out_addr, out_data, ea, ed);
        else n_pass++;
      end
      tick(); cyc++;
    end
    n_total++;
    if (words !== 8 || !done) $display("FAIL bp_count: got %0d words done=%b, want 8 and done", words, done);
    else n_pass++;
    tick();
  endtask

  task automatic test_wrap_single();
    int words, done_at;
    fill_identity();
    out_ready = 1'b1;
    start_dump(5'd30, 5'd1);
    drain("wrap", words, done_at);
    n_total++;
    if (words !== 4) $display("FAIL wrap_count: got %0d words, want 4", words);
    else n_pass++;
    start_dump(5'd7, 5'd7);
    drain("single", words, done_at);
    n_total++;
    if (words !== 1 || done_at !== 2) $display("FAIL single_count: got %0d words done_at=%0d, want 1 and 2", words, done_at);
    else n_pass++;
  endtask

  task automatic test_start_busy();
    int cyc, words;
    bit injected;
    logic [4:0]  ea;
    logic [31:0] ed;
    fill_identity();
    out_ready = 1'b1;
    start_dump(5'd0, 5'd5);
    cyc = 0; words = 0; injected = 1'b0;
    while (cyc < 200 && !done) begin
      if (out_valid && out_addr == 5'd2 && !injected) begin
        injected = 1'b1;
        first_addr = 5'd10; last_addr = 5'd12; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (out_valid && out_ready) begin
        words++;
        ea = sb_addr.pop_front();
        ed = sb_data.pop_front();
        n_total++;
        if ({out_addr, out_data} !== {ea, ed})
          $display("FAIL busy_start_word: got addr=%0d data=%h, want addr=%0d data=%h", out_addr, out_data, ea, ed);
        else n_pass++;
      end
      tick(); cyc++;
    end
    start = 1'b0;
    tick();
    tick();
    n_total++;
    if (words !== 6 || busy !== 1'b0) $display("FAIL busy_start_count: got %0d words busy=%b, want 6 and idle", words, busy);
    else n_pass++;
  endtask

  task automatic test_snapshot();
    int words, done_at, cyc;
    fill_identity();
    out_ready = 1'b1;
    start_dump(5'd0, 5'd5);
    cyc = 0;
    while (cyc < 100 && !(out_valid && out_addr == 5'd4)) begin
      if (out_valid) void'(sb_addr.pop_front());
      if (out_valid) void'(sb_data.pop_front());
      tick(); cyc++;
    end
    out_ready = 1'b0;
    rf[4] = 32'hDEADBEEF;
    tick(); tick();
    n_total++;
    if ({out_valid, out_addr, out_data} !== {1'b1, 5'd4, 32'd4})
      $display("FAIL snapshot: got valid=%b addr=%0d data=%h, want 1 4 00000004", out_valid, out_addr, out_data);
    else n_pass++;
    out_ready = 1'b1;
    drain("snapshot", words, done_at);
    n_total++;
    if (words !== 2) $display("FAIL snapshot_count: got %0d remaining words, want 2", words);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    int words, done_at, cyc;
    bit saw_done;
    fill_identity();
    out_ready = 1'b1;
    start_dump(5'd0, 5'd9);
    cyc = 0;
    while (cyc < 100 && !(out_valid && out_addr == 5'd5)) begin tick(); cyc++; end
    #3 reset = 1'b1;
    #1;
    n_total++;
    if ({out_valid, busy, out_addr, out_data, rf_addr} !== '0)
      $display("FAIL reset_mid_immediate: got valid=%b busy=%b addr=%0d data=%h rf_addr=%0d, want all 0",
               out_valid, busy, out_addr, out_data, rf_addr);
    else n_pass++;
    sb_addr.delete(); sb_data.delete();
    saw_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    reset = 1'b0;
    repeat (4) begin tick(); if (done || out_valid) saw_done = 1'b1; end
    n_total++;
    if (saw_done) $display("FAIL reset_mid_abandon: got done/valid after reset, want none");
    else n_pass++;
    start_dump(5'd12, 5'd14);
    drain("after_reset", words, done_at);
    n_total++;
    if (words !== 3) $display("FAIL after_reset_count: got %0d words, want 3", words);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_wrap_single();
    test_start_busy();
    test_snapshot();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
